seq_det_ctrl: RTL and testbench

Byte-serialising controller for the team's serial pattern-detection datapath. Accepts bytes over a valid/ready handshake and shifts each one MSB-first, one bit per clock, into an internal programmable pattern matcher. Reports a one-cycle match pulse, a saturating match count, and a per-byte done pulse. It is the bus-side front end that lets firmware or an upstream block drive the 101-style detector without bit-level timing.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_ctrl_if.sv | 33 +++
 rtl/pattern_match.sv | 56 +++++
 rtl/seq_det_ctrl.sv | 124 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the byte-serialising sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

  localparam int BYTE_W = 8;

  // Pattern loaded at reset: the classic "101" detector.
  localparam logic [2:0] PAT_DEFAULT = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Bus bundle between a byte source / config master and seq_det_ctrl.
// Latency: n/a (wires only).
// Backpressure: byte_valid/byte_ready handshake; the source holds the byte until ready.
// Ports: cfg_we/cfg_pattern/cfg_overlap (config), byte_valid/byte_data/byte_ready
//        (byte handshake), data_out/match_count/busy/done (status).
interface seq_det_ctrl_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  import seq_det_pkg::*;

  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              data_out;
  logic [CNT_W-1:0]  match_count;
  logic              busy;
  logic              done;

  modport master (
    output cfg_we, cfg_pattern, cfg_overlap, byte_valid, byte_data,
    input  byte_ready, data_out, match_count, busy, done
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_overlap, byte_valid, byte_data,
    output byte_ready, data_out, match_count, busy, done
  );

endinterface

// File: rtl/pattern_match.sv
// Serial pattern matcher: bit history, fill count, compare and overlap handling.
// Latency: match is combinational on the bit being consumed (bit_en && bit_in).
// Backpressure: none; consumes one bit per cycle whenever bit_en is high.
// Ports: clk, rstn (sync, active-low), clr (clear history), bit_en/bit_in (bit stream),
//        pattern (MSB = oldest bit), overlap, match.
module pattern_match #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  // Only the newest PAT_W-1 bits are needed; the incoming bit completes the window.
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign match = bit_en && (fill_q >= FILL_ARM) && ({hist_q, bit_in} == pattern);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en) begin
      hist_d = (PAT_W-1)'({hist_q, bit_in});
      // Non-overlapping: a new match must be built entirely from fresh bits.
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte front end for the serial pattern detector: shifts each accepted byte MSB-first.
// Latency: bit 7 consumed one cycle after handshake, done/next ready 9 cycles after it.
// Backpressure: byte_ready low while a byte is shifting or rstn is low; one byte per 9 cycles.
// Ports: clk, rstn (sync, active-low), bus (seq_det_ctrl_if.slave: config, byte
//        handshake, data_out pulse, saturating match_count, busy, done pulse).
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
  parameter int               CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rstn,
  seq_det_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(BYTE_W);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic              data_out_q;
  logic              done_q, done_d;

  logic pm_clr;
  logic bit_en;
  logic bit_in;
  logic match;
  logic handshake;

  assign bus.byte_ready  = rstn && (state_q == IDLE);
  assign bus.data_out    = data_out_q;
  assign bus.match_count = cnt_q;
  assign bus.busy        = (state_q == SHIFT);
  assign bus.done        = done_q;

  assign handshake = bus.byte_valid && bus.byte_ready;
  assign bit_en    = (state_q == SHIFT);
  assign bit_in    = shreg_q[idx_q];

  pattern_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (pm_clr),
    .bit_en  (bit_en),
    .bit_in  (bit_in),
    .pattern (pat_q),
    .overlap (ovl_q),
    .match   (match)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    done_d  = 1'b0;
    pm_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        // Config and a byte in the same cycle: the byte starts shifting next
        // cycle, so it naturally sees the new pattern and an empty history.
        if (bus.cfg_we) begin
          pat_d  = bus.cfg_pattern;
          ovl_d  = bus.cfg_overlap;
          pm_clr = 1'b1;
        end
        if (handshake) begin
          shreg_d = bus.byte_data;
          idx_d   = IDX_W'(BYTE_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The config clear only happens in IDLE and matches only in SHIFT, so they never collide.
  always_comb begin
    cnt_d = cnt_q;
    if (pm_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pat_q      <= PAT_RST;
      ovl_q      <= 1'b1;
      data_out_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      ovl_q      <= ovl_d;
      data_out_q <= match;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Testbench for seq_det_ctrl: directed test-plan steps plus randomized bytes/configs,
// checked cycle by cycle against a queue-based reference of the pattern rules.
// Two DUTs share stimulus: CNT_W = 8 and CNT_W = 2 (to exercise counter saturation).
module tb_seq_det_ctrl;

  localparam int PAT_W = 3;

  logic       clk;
  logic       rstn;
  logic       cfg_we;
  logic [2:0] cfg_pattern;
  logic       cfg_overlap;
  logic       byte_valid;
  logic [7:0] byte_data;

  int vectors;
  int fails;

  // Reference model state.
  bit         mq[$];
  logic [2:0] m_pat;
  bit         m_ovl;
  int         m_raw;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(8)) bus1 ();
  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(2)) bus2 ();

  assign bus1.cfg_we      = cfg_we;
  assign bus1.cfg_pattern = cfg_pattern;
  assign bus1.cfg_overlap = cfg_overlap;
  assign bus1.byte_valid  = byte_valid;
  assign bus1.byte_data   = byte_data;
  assign bus2.cfg_we      = cfg_we;
  assign bus2.cfg_pattern = cfg_pattern;
  assign bus2.cfg_overlap = cfg_overlap;
  assign bus2.byte_valid  = byte_valid;
  assign bus2.byte_data   = byte_data;

  seq_det_ctrl #(.PAT_W(PAT_W), .PAT_RST(3'b101), .CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  seq_det_ctrl #(.PAT_W(PAT_W), .PAT_RST(3'b101), .CNT_W(2)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int raw, input int maxv);
    return (raw > maxv) ? maxv : raw;
  endfunction

  // Push one bit into the reference window; report whether the newest PAT_W bits
  // equal the pattern. Non-overlap discards the window after a hit.
  function automatic bit model_bit(input bit b);
    int v;
    bit hit;
    mq.push_back(b);
    if (mq.size() > PAT_W) void'(mq.pop_front());
    hit = 1'b0;
    if (mq.size() == PAT_W) begin
      v = 0;
      foreach (mq[i]) v = v * 2 + int'(mq[i]);
      hit = (v == int'(m_pat));
    end
    if (hit && !m_ovl) mq.delete();
    return hit;
  endfunction

  task automatic model_cfg(input logic [2:0] p, input bit o);
    m_pat = p;
    m_ovl = o;
    mq.delete();
    m_raw = 0;
  endtask

  task automatic check_cycle(input string tag, input bit e_do, input bit e_done,
                             input bit e_busy, input bit e_rdy);
    chk({tag, ".data_out"},  32'(bus1.data_out),    32'(e_do));
    chk({tag, ".done"},      32'(bus1.done),        32'(e_done));
    chk({tag, ".busy"},      32'(bus1.busy),        32'(e_busy));
    chk({tag, ".ready"},     32'(bus1.byte_ready),  32'(e_rdy));
    chk({tag, ".count8"},    32'(bus1.match_count), 32'(sat(m_raw, 255)));
    chk({tag, ".count2"},    32'(bus2.match_count), 32'(sat(m_raw, 3)));
    chk({tag, ".data_out2"}, 32'(bus2.data_out),    32'(e_do));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic do_cfg(input logic [2:0] p, input bit o);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_overlap = o;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(p, o);
    check_cycle("cfg", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Handshake in the current cycle T, then check T+1..T+9; returns in T+9 (IDLE).
  task automatic send_byte(input logic [7:0] b, input bit cfg_now, input logic [2:0] np,
                           input bit novl, input bit cfg_mid);
    bit [7:0] hits;
    chk("pre.ready", 32'(bus1.byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data = b;
    if (cfg_now) begin
      cfg_we = 1'b1;
      cfg_pattern = np;
      cfg_overlap = novl;
      model_cfg(np, novl);
    end
    for (int j = 0; j < 8; j++) hits[j] = model_bit(b[7-j]);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    cfg_we = 1'b0;
    byte_data = 8'($urandom);
    for (int k = 1; k <= 9; k++) begin
      bit e_do;
      e_do = (k >= 2) && hits[k-2];
      if (e_do) m_raw++;
      check_cycle("byte", e_do, (k == 9), (k <= 8), (k == 9));
      if (cfg_mid && k == 3) begin
        cfg_we = 1'b1;
        cfg_pattern = 3'b110;
        cfg_overlap = ~m_ovl;
      end else begin
        cfg_we = 1'b0;
      end
      if (k < 9) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic reset_mid(input logic [7:0] b);
    bit [7:0] hits;
    byte_valid = 1'b1;
    byte_data = b;
    for (int j = 0; j < 8; j++) hits[j] = model_bit(b[7-j]);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bit e_do;
      e_do = (k >= 2) && hits[k-2];
      if (e_do) m_raw++;
      check_cycle("prerst", e_do, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    // Now in T+4.
    rstn = 1'b0;
    #1;
    chk("rst.ready_low", 32'(bus1.byte_ready), 32'd0);
    @(posedge clk); #1;
    model_cfg(3'b101, 1'b1);
    check_cycle("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    chk("rst.ready_high", 32'(bus1.byte_ready), 32'd1);
    idle(2);
  endtask

  initial begin
    vectors = 0;
    fails = 0;
    rstn = 1'b0;
    cfg_we = 1'b0;
    cfg_pattern = 3'b000;
    cfg_overlap = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    model_cfg(3'b101, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    chk("reset.ready", 32'(bus1.byte_ready), 32'd1);

    // Defaults: 0xA5 -> matches in T+4 and T+9.
    send_byte(8'hA5, 1'b0, 3'b0, 1'b0, 1'b0);
    chk("a5.count", 32'(bus1.match_count), 32'd2);

    // Non-overlap vs overlap on 0xAA.
    do_cfg(3'b101, 1'b0);
    send_byte(8'hAA, 1'b0, 3'b0, 1'b0, 1'b0);
    chk("aa_novl.count", 32'(bus1.match_count), 32'd2);
    do_cfg(3'b101, 1'b1);
    send_byte(8'hAA, 1'b0, 3'b0, 1'b0, 1'b0);
    chk("aa_ovl.count", 32'(bus1.match_count), 32'd3);

    // Cross-byte match.
    do_cfg(3'b101, 1'b1);
    send_byte(8'h02, 1'b0, 3'b0, 1'b0, 1'b0);
    send_byte(8'h80, 1'b0, 3'b0, 1'b0, 1'b0);
    chk("cross.count", 32'(bus1.match_count), 32'd1);

    // Saturation on the 2-bit counter.
    do_cfg(3'b101, 1'b1);
    send_byte(8'hAA, 1'b0, 3'b0, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 3'b0, 1'b0, 1'b0);
    chk("sat.count8", 32'(bus1.match_count), 32'd7);
    chk("sat.count2", 32'(bus2.match_count), 32'd3);

    // Config during SHIFT is ignored; in IDLE it clears and takes effect.
    send_byte(8'h00, 1'b0, 3'b0, 1'b0, 1'b1);
    chk("cfgshift.count", 32'(bus1.match_count), 32'd7);
    do_cfg(3'b110, 1'b1);
    chk("cfgidle.count", 32'(bus1.match_count), 32'd0);
    send_byte(8'hC0, 1'b0, 3'b0, 1'b0, 1'b0);
    chk("c0.count", 32'(bus1.match_count), 32'd1);

    // Config and handshake in the same cycle.
    send_byte(8'hB6, 1'b1, 3'b011, 1'b1, 1'b0);

    // Reset in the middle of a byte.
    reset_mid(8'hA5);
    chk("postrst.count", 32'(bus1.match_count), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) do_cfg(3'($urandom), 1'($urandom));
      send_byte(8'($urandom), ($urandom_range(0, 7) == 0), 3'($urandom), 1'($urandom),
                ($urandom_range(0, 9) == 0));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
